// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: assembles a big-endian byte stream into 16-bit instruction words and writes
// them to consecutive instruction-memory addresses from 0, holding the core in reset meanwhile.
module imem_loader #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ISIZE-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_wen,
  output logic [ISIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             xfer;
  logic             can_start;
  logic             launch;
  logic             too_big;
  logic             last_word;
  logic [7:0]       hi_byte;
  logic [ISIZE-1:0] word_cnt;
  logic [ISIZE-1:0] word_total;

  assign too_big   = 32'(word_count) > DEPTH;
  assign last_word = (word_cnt + ISIZE'(1)) == word_total;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    byte_ready = 1'b0;
    can_start  = 1'b0;
    launch     = 1'b0;
    xfer       = 1'b0;

    byte_ready = (state == S_HI) || (state == S_LO);
    xfer       = byte_valid && byte_ready;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        can_start = 1'b1;
        if (start) begin
          if (word_count == '0) begin
            state_next = S_DONE;
          end else if (too_big) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_HI;
            launch     = 1'b1;
          end
        end
      end
      S_HI: begin
        if (xfer) state_next = S_LO;
      end
      S_LO: begin
        if (xfer) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = last_word ? S_DONE : S_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      hi_byte    <= '0;
      word_cnt   <= '0;
      word_total <= '0;
    end else begin
      mem_wen  <= (state_next == S_WRITE);
      busy     <= (state_next == S_HI) || (state_next == S_LO) || (state_next == S_WRITE);
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERROR);
      cpu_hold <= (state_next != S_DONE);

      if (can_start && launch) begin
        word_total <= word_count;
        word_cnt   <= '0;
        mem_addr   <= '0;
      end

      if ((state == S_HI) && xfer) begin
        hi_byte <= byte_data;
      end

      if ((state == S_LO) && xfer) begin
        mem_data <= DSIZE'({hi_byte, byte_data});
        mem_addr <= word_cnt;
      end

      if (state == S_WRITE) begin
        word_cnt <= word_cnt + ISIZE'(1);
      end
    end
  end

endmodule
